// File: rtl/ace_fetch_ctrl.sv
// Fetch controller: one I-cache line in flight, 8-slot packet to decode.
// Optional perf counters enabled by defining ACE_FETCH_PERF_EN.
module ace_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         retire_flush_i,
   input  logic [31:0]  retire_redirect_pc_i,
   output logic         icache_req_vld_o,
   input  logic         icache_req_rdy_i,
   output logic [31:0]  icache_req_addr_o,
   input  logic         icache_rsp_vld_i,
   input  logic [255:0] icache_rsp_data_i,
   input  logic         instbuf_full_i,
   output logic [31:0]  fetch_inst0_o,
   output logic [31:0]  fetch_inst1_o,
   output logic [31:0]  fetch_inst2_o,
   output logic [31:0]  fetch_inst3_o,
   output logic [31:0]  fetch_inst4_o,
   output logic [31:0]  fetch_inst5_o,
   output logic [31:0]  fetch_inst6_o,
   output logic [31:0]  fetch_inst7_o,
   output logic         fetch_inst0_vld_o,
   output logic         fetch_inst1_vld_o,
   output logic         fetch_inst2_vld_o,
   output logic         fetch_inst3_vld_o,
   output logic         fetch_inst4_vld_o,
   output logic         fetch_inst5_vld_o,
   output logic         fetch_inst6_vld_o,
   output logic         fetch_inst7_vld_o,
   output logic [31:0]  fetch_pc_o
`ifdef ACE_FETCH_PERF_EN
   ,
   output logic [31:0]  perf_fetch_pkts_o,
   output logic [31:0]  perf_full_stall_o
`endif
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [31:0]   pc_q;
   logic [31:0]   pc_d;
   logic          drop_q;
   logic          drop_d;
   logic [255:0]  pkt_q;
   logic [7:0]    mask_q;
   logic [7:0]    mask_d;
   logic [31:0]   pkt_pc_q;
   logic          capture;
   logic          deliver;
   logic          req_hs;
   logic [7:0]    vld_all;

   assign req_hs = (state_q == S_REQ) && icache_req_rdy_i;

   always_comb begin
      mask_d = '0;
      for (int i = 0; i < 8; i++) begin
         mask_d[i] = (3'(i) >= pc_q[4:2]);
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      capture = 1'b0;
      deliver = 1'b0;
      if (retire_flush_i) begin
         pc_d    = retire_redirect_pc_i & ~32'h3;
         state_d = S_REQ;
         drop_d  = 1'b0;
         // A request is (or is about to be) outstanding: absorb its
         // response in WAIT before issuing the redirected request.
         if (req_hs ||
             (state_q == S_WAIT && !icache_rsp_vld_i)) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
         end
      end else begin
         unique case (state_q)
            S_REQ: begin
               if (icache_req_rdy_i) begin
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (icache_rsp_vld_i) begin
                  if (drop_q) begin
                     drop_d  = 1'b0;
                     state_d = S_REQ;
                  end else begin
                     capture = 1'b1;
                     state_d = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!instbuf_full_i) begin
                  deliver = 1'b1;
                  pc_d    = {pc_q[31:5] + 27'd1, 5'b0};
                  state_d = S_REQ;
               end
            end
            default: begin
               state_d = S_REQ;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_REQ;
         pc_q     <= RESET_PC & ~32'h3;
         drop_q   <= 1'b0;
         pkt_q    <= '0;
         mask_q   <= '0;
         pkt_pc_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
         if (capture) begin
            pkt_q    <= icache_rsp_data_i;
            mask_q   <= mask_d;
            pkt_pc_q <= pc_q;
         end
      end
   end

   assign icache_req_vld_o  = (state_q == S_REQ) && !reset;
   assign icache_req_addr_o = {pc_q[31:5], 5'b0};

   assign vld_all = (deliver && !reset) ? mask_q : 8'h00;

   assign fetch_inst0_o = pkt_q[31:0];
   assign fetch_inst1_o = pkt_q[63:32];
   assign fetch_inst2_o = pkt_q[95:64];
   assign fetch_inst3_o = pkt_q[127:96];
   assign fetch_inst4_o = pkt_q[159:128];
   assign fetch_inst5_o = pkt_q[191:160];
   assign fetch_inst6_o = pkt_q[223:192];
   assign fetch_inst7_o = pkt_q[255:224];

   assign fetch_inst0_vld_o = vld_all[0];
   assign fetch_inst1_vld_o = vld_all[1];
   assign fetch_inst2_vld_o = vld_all[2];
   assign fetch_inst3_vld_o = vld_all[3];
   assign fetch_inst4_vld_o = vld_all[4];
   assign fetch_inst5_vld_o = vld_all[5];
   assign fetch_inst6_vld_o = vld_all[6];
   assign fetch_inst7_vld_o = vld_all[7];

   assign fetch_pc_o = pkt_pc_q;

`ifdef ACE_FETCH_PERF_EN
   logic [31:0] pkts_q;
   logic [31:0] stall_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         pkts_q  <= '0;
         stall_q <= '0;
      end else begin
         if (deliver && pkts_q != 32'hFFFF_FFFF) begin
            pkts_q <= pkts_q + 32'd1;
         end
         if (state_q == S_HOLD && instbuf_full_i &&
             stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
         end
      end
   end

   assign perf_fetch_pkts_o = pkts_q;
   assign perf_full_stall_o = stall_q;
`endif

   // Only one line may be outstanding, so data outside WAIT is illegal.
   a_rsp_in_wait: assert property (
      @(posedge clock) disable iff (reset)
      icache_rsp_vld_i |-> (state_q == S_WAIT)
   );

endmodule

// File: tb/tb_ace_fetch_ctrl.sv
// Bench for ace_fetch_ctrl: vector table plus packet scoreboard.
// Hand sequences cover flush-in-WAIT, flush-with-response and reset.
module tb_ace_fetch_ctrl;

   logic         clock;
   logic         reset;
   logic         flush;
   logic [31:0]  redirect;
   logic         req_vld;
   logic         rdy;
   logic [31:0]  addr;
   logic         rsp;
   logic [255:0] rsp_data;
   logic         full;
   logic [31:0]  inst [8];
   logic [7:0]   vlds;
   logic [31:0]  fpc;
   logic [255:0] pkt_out;
`ifdef ACE_FETCH_PERF_EN
   logic [31:0]  perf_pkts;
   logic [31:0]  perf_stall;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        flush;
      logic [31:0] fpc;
      int          lat;
      int          stall;
      logic [31:0] addr;
      logic [7:0]  vld;
      logic [31:0] pc;
      logic [31:0] seed;
   } vec_t;

   typedef struct {
      logic [255:0] data;
      logic [7:0]   vld;
      logic [31:0]  pc;
   } exp_t;

   exp_t         sbq[$];
   vec_t         vecs[8];
   logic [255:0] last_data;
   logic [255:0] stale;

   ace_fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
      .clock                (clock),
      .reset                (reset),
      .retire_flush_i       (flush),
      .retire_redirect_pc_i (redirect),
      .icache_req_vld_o     (req_vld),
      .icache_req_rdy_i     (rdy),
      .icache_req_addr_o    (addr),
      .icache_rsp_vld_i     (rsp),
      .icache_rsp_data_i    (rsp_data),
      .instbuf_full_i       (full),
      .fetch_inst0_o        (inst[0]),
      .fetch_inst1_o        (inst[1]),
      .fetch_inst2_o        (inst[2]),
      .fetch_inst3_o        (inst[3]),
      .fetch_inst4_o        (inst[4]),
      .fetch_inst5_o        (inst[5]),
      .fetch_inst6_o        (inst[6]),
      .fetch_inst7_o        (inst[7]),
      .fetch_inst0_vld_o    (vlds[0]),
      .fetch_inst1_vld_o    (vlds[1]),
      .fetch_inst2_vld_o    (vlds[2]),
      .fetch_inst3_vld_o    (vlds[3]),
      .fetch_inst4_vld_o    (vlds[4]),
      .fetch_inst5_vld_o    (vlds[5]),
      .fetch_inst6_vld_o    (vlds[6]),
      .fetch_inst7_vld_o    (vlds[7]),
      .fetch_pc_o           (fpc)
`ifdef ACE_FETCH_PERF_EN
      ,
      .perf_fetch_pkts_o    (perf_pkts),
      .perf_full_stall_o    (perf_stall)
`endif
   );

   assign pkt_out = {inst[7], inst[6], inst[5], inst[4],
                     inst[3], inst[2], inst[1], inst[0]};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name,
                      input logic [255:0] act,
                      input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] mk_data(input logic [31:0] seed);
      logic [255:0] d;
      for (int i = 0; i < 8; i++) begin
         d[32*i +: 32] = seed + 32'(i);
      end
      return d;
   endfunction

   task automatic wait_req();
      int n = 0;
      while (req_vld !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("req_timeout", 256'(req_vld), 256'd1);
   endtask

   task automatic run_vec(input vec_t v);
      exp_t e;
      if (v.flush) begin
         flush    = 1'b1;
         redirect = v.fpc;
         #1;
         chk("flush_vld", 256'(vlds), 256'd0);
         tick();
         flush = 1'b0;
      end
      wait_req();
      chk("req_addr", 256'(addr), 256'(v.addr));
      e.data = mk_data(v.seed);
      e.vld  = v.vld;
      e.pc   = v.pc;
      sbq.push_back(e);
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      for (int w = 1; w < v.lat; w++) begin
         chk("wait_vld", 256'(vlds), 256'd0);
         tick();
      end
      rsp      = 1'b1;
      rsp_data = e.data;
      full     = (v.stall > 0);
      tick();
      rsp      = 1'b0;
      rsp_data = '0;
      for (int s = 0; s < v.stall; s++) begin
         full = 1'b1;
         #1;
         chk("stall_vld", 256'(vlds), 256'd0);
         chk("stall_data", pkt_out, sbq[0].data);
         chk("stall_pc", 256'(fpc), 256'(sbq[0].pc));
         tick();
      end
      full = 1'b0;
      #1;
      e = sbq.pop_front();
      chk("pkt_vld", 256'(vlds), 256'(e.vld));
      chk("pkt_data", pkt_out, e.data);
      chk("pkt_pc", 256'(fpc), 256'(e.pc));
      last_data = e.data;
      tick();
      chk("post_vld", 256'(vlds), 256'd0);
   endtask

   initial begin
      vecs[0] = '{1'b0, 32'h0, 2, 0, 32'h100, 8'hFF,
                  32'h100, 32'h1111_0000};
      vecs[1] = '{1'b0, 32'h0, 2, 0, 32'h120, 8'hFF,
                  32'h120, 32'h2222_0000};
      vecs[2] = '{1'b1, 32'h20C, 2, 0, 32'h200, 8'hF8,
                  32'h20C, 32'h3333_0000};
      vecs[3] = '{1'b0, 32'h0, 3, 5, 32'h220, 8'hFF,
                  32'h220, 32'h4444_0000};
      vecs[4] = '{1'b1, 32'h1C, 2, 0, 32'h0, 8'h80,
                  32'h1C, 32'h5555_0000};
      vecs[5] = '{1'b1, 32'hFFFF_FFE5, 2, 0, 32'hFFFF_FFE0,
                  8'hFE, 32'hFFFF_FFE4, 32'h6666_0000};
      vecs[6] = '{1'b0, 32'h0, 2, 0, 32'h0, 8'hFF,
                  32'h0, 32'h7777_0000};
      vecs[7] = '{1'b1, 32'h3, 1, 0, 32'h0, 8'hFF,
                  32'h0, 32'h8888_0000};
      stale = {8{32'hDEAD_BEEF}};

      reset    = 1'b1;
      flush    = 1'b0;
      redirect = '0;
      rdy      = 1'b0;
      rsp      = 1'b0;
      rsp_data = '0;
      full     = 1'b0;
      tick();
      chk("rst_req_vld", 256'(req_vld), 256'd0);
      chk("rst_vld", 256'(vlds), 256'd0);
      chk("rst_pc", 256'(fpc), 256'd0);
      chk("rst_data", pkt_out, 256'd0);
      reset = 1'b0;
      #1;
      chk("rst_addr", 256'(addr), 256'h100);

      foreach (vecs[i]) run_vec(vecs[i]);

`ifdef ACE_FETCH_PERF_EN
      chk("perf_pkts", 256'(perf_pkts), 256'd8);
      chk("perf_stall", 256'(perf_stall), 256'd5);
`endif

      // flush while waiting; stale response must be swallowed
      wait_req();
      chk("a_addr", 256'(addr), 256'h20);
      rdy = 1'b1;
      tick();
      rdy      = 1'b0;
      flush    = 1'b1;
      redirect = 32'h400;
      #1;
      chk("a_flush_vld", 256'(vlds), 256'd0);
      tick();
      flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("a_no_req", 256'(req_vld), 256'd0);
         tick();
      end
      rsp      = 1'b1;
      rsp_data = stale;
      #1;
      chk("a_stale_vld", 256'(vlds), 256'd0);
      chk("a_stale_req", 256'(req_vld), 256'd0);
      tick();
      rsp      = 1'b0;
      rsp_data = '0;
      chk("a_req_vld", 256'(req_vld), 256'd1);
      chk("a_req_addr", 256'(addr), 256'h400);
      chk("a_data_kept", pkt_out, last_data);
      run_vec('{1'b0, 32'h0, 2, 0, 32'h400, 8'hFF,
                32'h400, 32'h9999_0000});

      // flush in the same cycle as the response
      wait_req();
      chk("b_addr", 256'(addr), 256'h420);
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      tick();
      rsp      = 1'b1;
      rsp_data = stale;
      flush    = 1'b1;
      redirect = 32'h600;
      #1;
      chk("b_vld", 256'(vlds), 256'd0);
      tick();
      rsp      = 1'b0;
      rsp_data = '0;
      flush    = 1'b0;
      chk("b_req_vld", 256'(req_vld), 256'd1);
      chk("b_req_addr", 256'(addr), 256'h600);
      chk("b_data_kept", pkt_out, last_data);
      run_vec('{1'b0, 32'h0, 2, 0, 32'h600, 8'hFF,
                32'h600, 32'hAAAA_0000});

      // flush coinciding with request acceptance
      wait_req();
      chk("c_addr", 256'(addr), 256'h620);
      rdy      = 1'b1;
      flush    = 1'b1;
      redirect = 32'h800;
      tick();
      rdy   = 1'b0;
      flush = 1'b0;
      chk("c_no_req", 256'(req_vld), 256'd0);
      tick();
      rsp      = 1'b1;
      rsp_data = stale;
      tick();
      rsp      = 1'b0;
      rsp_data = '0;
      chk("c_req_vld", 256'(req_vld), 256'd1);
      chk("c_req_addr", 256'(addr), 256'h800);
      run_vec('{1'b0, 32'h0, 2, 0, 32'h800, 8'hFF,
                32'h800, 32'hBBBB_0000});

      // reset while holding a packet
      wait_req();
      chk("d_addr", 256'(addr), 256'h820);
      rdy = 1'b1;
      tick();
      rdy      = 1'b0;
      rsp      = 1'b1;
      rsp_data = mk_data(32'hCCCC_0000);
      full     = 1'b1;
      tick();
      rsp      = 1'b0;
      rsp_data = '0;
      chk("d_hold_vld", 256'(vlds), 256'd0);
      reset = 1'b1;
      full  = 1'b0;
      #1;
      chk("d_rst_vld", 256'(vlds), 256'd0);
      chk("d_rst_req", 256'(req_vld), 256'd0);
      tick();
      reset = 1'b0;
      #1;
      chk("d_req_vld", 256'(req_vld), 256'd1);
      chk("d_req_addr", 256'(addr), 256'h100);
      chk("d_pc", 256'(fpc), 256'd0);
      chk("d_data", pkt_out, 256'd0);
      run_vec('{1'b0, 32'h0, 2, 0, 32'h100, 8'hFF,
                32'h100, 32'hDDDD_0000});

      chk("sb_empty", 256'(sbq.size()), 256'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
